// File: rtl/fp_add_pkg.sv
// Shared state, flag types and width helpers for the sequential floating-point adder.
// The FP_ADD_SPECIALS_EN macro (zero/Inf/NaN handling) is consumed by fp_unpack and fp_add_seq.
package fp_add_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_e;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
    } flags_t;

    function automatic int fp_word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Hidden bit plus one carry bit above the stored fraction.
    function automatic int fp_sum_w(input int man_w);
        return man_w + 2;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits an operand into sign/exponent/mantissa with the hidden bit restored.
// With FP_ADD_SPECIALS_EN defined it also classifies zero, Inf and NaN encodings.
module fp_unpack
    import fp_add_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic [EXP_W+MAN_W:0] word,
`ifdef FP_ADD_SPECIALS_EN
    output logic                 is_zero,
    output logic                 is_inf,
    output logic                 is_nan,
`endif
    output logic                 sign,
    output logic [EXP_W-1:0]     expo,
    output logic [MAN_W:0]       mant
);

    logic [MAN_W-1:0] frac;

    assign sign = word[EXP_W+MAN_W];
    assign expo = word[EXP_W+MAN_W-1:MAN_W];
    assign frac = word[MAN_W-1:0];

`ifdef FP_ADD_SPECIALS_EN
    // A zero exponent also covers denormals, whose fraction is flushed.
    assign is_zero = (expo == '0);
    assign is_inf  = (expo == '1) && (frac == '0);
    assign is_nan  = (expo == '1) && (frac != '0);
    assign mant    = is_zero ? '0 : {1'b1, frac};
`else
    assign mant    = {1'b1, frac};
`endif

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle floating-point adder: align, add, then normalise one bit per cycle; truncating.
// Define FP_ADD_SPECIALS_EN for zero/Inf/NaN handling and Inf on overflow.
module fp_add_seq
    import fp_add_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [2:0]           flags,
    output logic                 busy
);

    localparam int WORD_W = fp_word_w(EXP_W, MAN_W);
    localparam int SUM_W  = fp_sum_w(MAN_W);
    localparam logic [EXP_W:0] EXP_LIMIT = {1'b0, {EXP_W{1'b1}}};

    state_e state, state_next;
    flags_t flags_q;
    logic [WORD_W-1:0] res_q;

    logic             ua_sign, ub_sign;
    logic [EXP_W-1:0] ua_exp, ub_exp;
    logic [MAN_W:0]   ua_mant, ub_mant;

    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W:0]   mant_a, mant_b;

    logic             big_sign, small_sign;
    logic [EXP_W-1:0] big_exp;
    logic [MAN_W:0]   big_mant, small_mant;

    logic [SUM_W-1:0] sum_q;
    logic [EXP_W-1:0] exp_q;
    logic             sign_q;

    logic             accept;
    logic [SUM_W-1:0] add_raw, add_sum;
    logic             add_sign, add_carry, add_ovf;
    logic [EXP_W:0]   add_exp;
    logic             sum_zero, sum_norm, exp_one;

    function automatic logic [MAN_W:0] align_shift(input logic [MAN_W:0] m,
                                                   input logic [EXP_W-1:0] d);
        if (int'(d) >= MAN_W + 1) return '0;
        return m >> d;
    endfunction

    function automatic logic [WORD_W-1:0] ovf_word(input logic s);
`ifdef FP_ADD_SPECIALS_EN
        return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
        return {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
    endfunction

`ifdef FP_ADD_SPECIALS_EN
    logic ua_zero, ua_inf, ua_nan, ub_zero, ub_inf, ub_nan;
    logic special;
    logic [WORD_W-1:0] spec_res;
    flags_t spec_flags;

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .word(a), .is_zero(ua_zero), .is_inf(ua_inf), .is_nan(ua_nan),
        .sign(ua_sign), .expo(ua_exp), .mant(ua_mant)
    );
    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .word(b), .is_zero(ub_zero), .is_inf(ub_inf), .is_nan(ub_nan),
        .sign(ub_sign), .expo(ub_exp), .mant(ub_mant)
    );

    assign special = ua_zero | ua_inf | ua_nan | ub_zero | ub_inf | ub_nan;

    always_comb begin
        spec_res   = '0;
        spec_flags = '0;
        if (ua_nan || ub_nan || (ua_inf && ub_inf && (ua_sign != ub_sign)))
            spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        else if (ua_inf)
            spec_res = {ua_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (ub_inf)
            spec_res = {ub_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (ua_zero && ub_zero)
            spec_flags.zero = 1'b1;
        else if (ua_zero)
            spec_res = b;
        else
            spec_res = a;
    end
`else
    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .word(a), .sign(ua_sign), .expo(ua_exp), .mant(ua_mant)
    );
    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .word(b), .sign(ub_sign), .expo(ub_exp), .mant(ub_mant)
    );
`endif

    assign accept    = in_valid && (state == IDLE);
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_q;
    assign flags     = flags_q;

    // Signed-magnitude add; the larger magnitude decides the sign, exact cancellation gives +0.
    always_comb begin
        add_raw  = '0;
        add_sign = big_sign;
        if (big_sign == small_sign) begin
            add_raw = {1'b0, big_mant} + {1'b0, small_mant};
        end else if (big_mant >= small_mant) begin
            add_raw = {1'b0, big_mant} - {1'b0, small_mant};
        end else begin
            add_raw  = {1'b0, small_mant} - {1'b0, big_mant};
            add_sign = small_sign;
        end
        if (add_raw == '0) add_sign = 1'b0;
    end

    assign add_carry = add_raw[SUM_W-1];
    assign add_sum   = add_carry ? (add_raw >> 1) : add_raw;
    assign add_exp   = {1'b0, big_exp} + {{EXP_W{1'b0}}, add_carry};
    assign add_ovf   = (add_exp >= EXP_LIMIT);

    assign sum_zero = (sum_q == '0);
    assign sum_norm = sum_q[MAN_W];
    assign exp_one  = (exp_q == {{(EXP_W-1){1'b0}}, 1'b1});

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef FP_ADD_SPECIALS_EN
                    state_next = special ? DONE : ALIGN;
`else
                    state_next = ALIGN;
`endif
                end
            end
            ALIGN: state_next = ADD;
            ADD:   state_next = add_ovf ? DONE : NORM;
            NORM:  if (sum_zero || sum_norm || exp_one) state_next = DONE;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state <= state_next;
            case (state)
`ifdef FP_ADD_SPECIALS_EN
                IDLE: begin
                    if (accept && special) begin
                        res_q   <= spec_res;
                        flags_q <= spec_flags;
                    end
                end
`endif
                ADD: begin
                    if (add_ovf) begin
                        res_q   <= ovf_word(add_sign);
                        flags_q <= '{ovf: 1'b1, unf: 1'b0, zero: 1'b0};
                    end
                end
                NORM: begin
                    if (sum_zero) begin
                        res_q   <= '0;
                        flags_q <= '{ovf: 1'b0, unf: 1'b0, zero: 1'b1};
                    end else if (sum_norm) begin
                        res_q   <= {sign_q, exp_q, sum_q[MAN_W-1:0]};
                        flags_q <= '0;
                    end else if (exp_one) begin
                        res_q   <= '0;
                        flags_q <= '{ovf: 1'b0, unf: 1'b1, zero: 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    // p0: capture operands; p1: align; p2: add; p3+: normalise in place.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    sign_a <= ua_sign;
                    sign_b <= ub_sign;
                    exp_a  <= ua_exp;
                    exp_b  <= ub_exp;
                    mant_a <= ua_mant;
                    mant_b <= ub_mant;
                end
            end
            ALIGN: begin
                if (exp_a >= exp_b) begin
                    big_sign   <= sign_a;
                    big_exp    <= exp_a;
                    big_mant   <= mant_a;
                    small_sign <= sign_b;
                    small_mant <= align_shift(mant_b, exp_a - exp_b);
                end else begin
                    big_sign   <= sign_b;
                    big_exp    <= exp_b;
                    big_mant   <= mant_b;
                    small_sign <= sign_a;
                    small_mant <= align_shift(mant_a, exp_b - exp_a);
                end
            end
            ADD: begin
                sum_q  <= add_sum;
                exp_q  <= add_exp[EXP_W-1:0];
                sign_q <= add_sign;
            end
            NORM: begin
                if (!sum_zero && !sum_norm) begin
                    sum_q <= sum_q << 1;
                    exp_q <= exp_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq (single precision) with an arithmetic reference model.
// Expectations follow FP_ADD_SPECIALS_EN when it is defined.
`timescale 1ns/1ps
module tb_fp_add_seq;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready;
    logic        in_ready, out_valid, busy;
    logic [31:0] a, b, result;
    logic [2:0]  flags;

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    bit   seen = 1'b0;

    fp_add_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        asserts++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
        end
    endtask

    // Reference: real-valued signed sum of truncation-aligned mantissas, then renormalise.
    function automatic void model(input logic [31:0] va, input logic [31:0] vb, output exp_t m);
        longint mbig, msm, s, mag;
        int     ebig, esm, d, e, lz;
        logic   sbig, ssm, sg;
        m.r = 32'h0; m.f = 3'b000; m.lat = 4; m.acc = 0;
`ifdef FP_ADD_SPECIALS_EN
        begin
            bit za, zb, ia, ib, na, nb;
            za = (va[30:23] == 8'h00);
            zb = (vb[30:23] == 8'h00);
            ia = (va[30:23] == 8'hFF) && (va[22:0] == 0);
            ib = (vb[30:23] == 8'hFF) && (vb[22:0] == 0);
            na = (va[30:23] == 8'hFF) && (va[22:0] != 0);
            nb = (vb[30:23] == 8'hFF) && (vb[22:0] != 0);
            if (za || zb || ia || ib || na || nb) begin
                m.lat = 1;
                if (na || nb || (ia && ib && va[31] != vb[31])) m.r = 32'h7FC00000;
                else if (ia) m.r = {va[31], 8'hFF, 23'h0};
                else if (ib) m.r = {vb[31], 8'hFF, 23'h0};
                else if (za && zb) m.f = 3'b001;
                else if (za) m.r = vb;
                else m.r = va;
                return;
            end
        end
`endif
        if (va[30:23] >= vb[30:23]) begin
            sbig = va[31]; ebig = int'(va[30:23]); mbig = longint'({1'b1, va[22:0]});
            ssm  = vb[31]; esm  = int'(vb[30:23]); msm  = longint'({1'b1, vb[22:0]});
        end else begin
            sbig = vb[31]; ebig = int'(vb[30:23]); mbig = longint'({1'b1, vb[22:0]});
            ssm  = va[31]; esm  = int'(va[30:23]); msm  = longint'({1'b1, va[22:0]});
        end
        d   = ebig - esm;
        msm = (d >= 24) ? 0 : (msm >> d);
        s   = (sbig ? -mbig : mbig) + (ssm ? -msm : msm);
        if (s == 0) begin
            m.f = 3'b001;
            return;
        end
        sg  = (s < 0);
        mag = sg ? -s : s;
        e   = ebig;
        if (mag >= (64'sd1 <<< 24)) begin
            mag = mag >> 1;
            e++;
        end
        if (e >= 255) begin
`ifdef FP_ADD_SPECIALS_EN
            m.r = {sg, 8'hFF, 23'h000000};
`else
            m.r = {sg, 8'hFE, 23'h7FFFFF};
`endif
            m.f = 3'b100; m.lat = -1;
            return;
        end
        lz = 0;
        while (mag < (64'sd1 <<< 23)) begin
            if (e == 1) begin
                m.r = 32'h0; m.f = 3'b011; m.lat = 4 + lz;
                return;
            end
            mag = mag << 1;
            e--;
            lz++;
        end
        m.r = {sg, 8'(e), 23'(mag)};
        m.lat = 4 + lz;
    endfunction

    // Every cycle a result is presented it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                asserts++;
                fails++;
                $display("FAIL unexpected_result: got 0x%08h, required no output", result);
            end else begin
                check("result", result, exp_q[0].r);
                check("flags", {29'b0, flags}, {29'b0, exp_q[0].f});
                if (!seen) begin
                    seen = 1'b1;
                    if (exp_q[0].lat >= 0) check("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic run_op(input string nm, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] lit_r, input logic [2:0] lit_f,
                          input int lit_lat, input int hold);
        exp_t m;
        int   n;
        model(va, vb, m);
        check({nm, "_model_r"}, m.r, lit_r);
        check({nm, "_model_f"}, {29'b0, m.f}, {29'b0, lit_f});
        check({nm, "_model_lat"}, m.lat, lit_lat);
        m.acc = cyc;
        exp_q.push_back(m);
        a = va; b = vb; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            asserts++;
            fails++;
            $display("FAIL %s_timeout: got no out_valid, required one within 100 cycles", nm);
            exp_q.delete();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check({nm, "_in_ready_hold"}, {31'b0, in_ready}, 32'h0);
            @(posedge clk); #1;
        end
        if (hold > 0) check({nm, "_valid_held"}, {31'b0, out_valid}, 32'h1);
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_valid_drop"}, {31'b0, out_valid}, 32'h0);
        check({nm, "_ready_back"}, {31'b0, in_ready}, 32'h1);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_flags", {29'b0, flags}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 4, 0);
        run_op("cancel",       32'h3FC00000, 32'hBFC00000, 32'h00000000, 3'b001, 4, 0);
        run_op("trunc_lz23",   32'h3F800000, 32'hBF7FFFFF, 32'h34000000, 3'b000, 27, 0);
        run_op("far_align",    32'h3F800000, 32'h30800000, 32'h3F800000, 3'b000, 4, 0);
        run_op("sub_lz1",      32'h3FC00000, 32'hBF800000, 32'h3F000000, 3'b000, 5, 0);
        run_op("neg_larger",   32'h3F800000, 32'hC0000000, 32'hBF800000, 3'b000, 5, 0);
        run_op("underflow",    32'h00800000, 32'h80C00000, 32'h00000000, 3'b011, 4, 0);
`ifdef FP_ADD_SPECIALS_EN
        run_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b100, -1, 0);
        run_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b000, 1, 0);
`else
        run_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 3'b100, -1, 0);
`endif
        run_op("backpressure", 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 4, 3);

        // Abort a long normalisation with reset; nothing may be reported for it.
        a = 32'h3F800000; b = 32'hBF7FFFFF; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
        reset = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;

        run_op("after_reset", 32'h3FC00000, 32'hBF800000, 32'h3F000000, 3'b000, 5, 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
